sum_window_avg: RTL and testbench

Downstream consumer of the registered 9-bit adder result stream (ui_in + uio_in, carry in bit 8).
- Keeps a sliding window of the last 2^LOG2_N samples in a circular buffer.
- Maintains a running sum and presents the window average through a valid/ready output register.
- Runs on the main clk; the upstream half-rate update is seen only as an in_valid strobe, never as a clock.

---
 rtl/sum_pkg.sv | 15 +
 rtl/sum_window_avg_if.sv | 30 +++
 rtl/sum_window_buf.sv | 27 ++
 rtl/sum_window_avg.sv | 101 ++++++++++
 tb/tb_sum_window_avg.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/sum_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sum_pkg
// Purpose  : Shared widths and types for the sliding-window averager.
// Revision : 1.0 - initial release
// ============================================================================
package sum_pkg;
    localparam int DATA_W = 9;
    localparam int LOG2_N = 3;
    localparam int N      = 1 << LOG2_N;
    localparam int ACC_W  = DATA_W + LOG2_N;

    typedef logic [DATA_W-1:0] sample_t;
endpackage
`default_nettype wire

// File: rtl/sum_window_avg_if.sv
`default_nettype none
// ============================================================================
// Module   : sum_window_avg_if
// Purpose  : Sample-in strobe and valid/ready average-out bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface sum_window_avg_if;
    import sum_pkg::*;

    logic    in_valid;
    sample_t in_data;
    logic    out_valid;
    logic    out_ready;
    sample_t out_avg;
    logic    out_full;
    logic    overrun;

    // Producer and consumer side
    modport master (
        output in_valid, in_data, out_ready,
        input  out_valid, out_avg, out_full, overrun
    );

    // Averager side
    modport slave (
        input  in_valid, in_data, out_ready,
        output out_valid, out_avg, out_full, overrun
    );
endinterface
`default_nettype wire

// File: rtl/sum_window_buf.sv
`default_nettype none
// ============================================================================
// Module   : sum_window_buf
// Purpose  : N x DATA_W register file, single shared index for write/read.
// Revision : 1.0 - initial release
// ============================================================================
module sum_window_buf
    import sum_pkg::*;
(
    input  logic              clk,
    input  logic              wr_en,
    input  logic [LOG2_N-1:0] idx,
    input  sample_t           wr_data,
    output sample_t           rd_data
);
    // Storage is deliberately unreset; stale entries are masked by the count.
    sample_t mem [N];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[idx] <= wr_data;
        end
    end

    assign rd_data = mem[idx];
endmodule
`default_nettype wire

// File: rtl/sum_window_avg.sv
`default_nettype none
// ============================================================================
// Module   : sum_window_avg
// Purpose  : Running sum over the last N samples, average via valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module sum_window_avg
    import sum_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    sum_window_avg_if.slave  bus
);
    localparam logic [LOG2_N:0] FULL_CNT = (LOG2_N+1)'(N);

    logic [LOG2_N-1:0] wr_ptr_q, wr_ptr_d;
    logic [LOG2_N:0]   count_q, count_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    sample_t           avg_q, avg_d;
    logic              valid_q, valid_d;
    logic              full_q, full_d;
    logic              overrun_q, overrun_d;

    logic              wr_en;
    sample_t           rd_data;
    sample_t           old_sample;
    logic [ACC_W-1:0]  acc_next;

    assign wr_en = bus.in_valid & ~clr;

    sum_window_buf u_buf (
        .clk     (clk),
        .wr_en   (wr_en),
        .idx     (wr_ptr_q),
        .wr_data (bus.in_data),
        .rd_data (rd_data)
    );

    // Until the window is full, the slot being overwritten holds no real sample.
    assign old_sample = (count_q == FULL_CNT) ? rd_data : '0;
    assign acc_next   = acc_q + ACC_W'(bus.in_data) - ACC_W'(old_sample);

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        acc_d     = acc_q;
        avg_d     = avg_q;
        valid_d   = valid_q;
        full_d    = full_q;
        overrun_d = overrun_q;

        if (clr) begin
            wr_ptr_d  = '0;
            count_d   = '0;
            acc_d     = '0;
            avg_d     = '0;
            valid_d   = 1'b0;
            full_d    = 1'b0;
            overrun_d = 1'b0;
        end else if (bus.in_valid) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            count_d  = (count_q == FULL_CNT) ? FULL_CNT : count_q + 1'b1;
            acc_d    = acc_next;
            avg_d    = acc_next[ACC_W-1:LOG2_N];
            valid_d  = 1'b1;
            full_d   = (count_d == FULL_CNT);
            if (valid_q && !bus.out_ready) begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && bus.out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            count_q   <= '0;
            acc_q     <= '0;
            avg_q     <= '0;
            valid_q   <= 1'b0;
            full_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            acc_q     <= acc_d;
            avg_q     <= avg_d;
            valid_q   <= valid_d;
            full_q    <= full_d;
            overrun_q <= overrun_d;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_avg   = avg_q;
    assign bus.out_full  = full_q;
    assign bus.overrun   = overrun_q;
endmodule
`default_nettype wire

// File: tb/tb_sum_window_avg.sv
`default_nettype none
// ============================================================================
// Module   : tb_sum_window_avg
// Purpose  : Directed and random checks of the window averager against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sum_window_avg;
    logic clk;
    logic rst_n;
    logic clr;

    sum_window_avg_if bus ();

    sum_window_avg dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference: the window is literally the last <=8 samples seen.
    int unsigned win [$];
    int unsigned m_avg;
    logic        m_valid;
    logic        m_full;
    logic        m_ovr;

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        win.delete();
        m_avg   = 0;
        m_valid = 1'b0;
        m_full  = 1'b0;
        m_ovr   = 1'b0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"},   32'(bus.out_valid), 32'(m_valid));
        chk({tag, ".avg"},     32'(bus.out_avg),   m_avg);
        chk({tag, ".full"},    32'(bus.out_full),  32'(m_full));
        chk({tag, ".overrun"}, 32'(bus.overrun),   32'(m_ovr));
    endtask

    // One clock: drive inputs, clock, advance model, compare everything.
    task automatic step(input logic v, input int unsigned d, input logic rdy,
                        input logic c, input string tag);
        int unsigned s;
        bus.in_valid  = v;
        bus.in_data   = 9'(d);
        bus.out_ready = rdy;
        clr           = c;
        @(posedge clk);
        #1;
        if (c) begin
            model_reset();
        end else if (v) begin
            if (m_valid && !rdy) m_ovr = 1'b1;
            win.push_back(d);
            if (win.size() > 8) void'(win.pop_front());
            s = 0;
            foreach (win[i]) s += win[i];
            m_avg   = s / 8;
            m_valid = 1'b1;
            m_full  = (win.size() == 8);
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        bus.in_valid = 1'b0;
        clr          = 1'b0;
        check_all(tag);
    endtask

    initial begin
        rst_n         = 1'b0;
        clr           = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 9'd55;
        bus.out_ready = 1'b1;
        model_reset();

        // Reset held with strobes active
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        step(1'b0, 0, 1'b1, 1'b0, "post_reset_idle");

        // Fill
        for (int i = 0; i < 8; i++) step(1'b1, 100, 1'b1, 1'b0, "fill");
        chk("fill_last_avg", 32'(bus.out_avg), 100);
        chk("fill_last_full", 32'(bus.out_full), 1);

        // Wrap down with zeros
        step(1'b1, 0, 1'b1, 1'b0, "wrap0");
        chk("wrap_first_avg", 32'(bus.out_avg), 87);
        for (int i = 0; i < 7; i++) step(1'b1, 0, 1'b1, 1'b0, "wrap");
        chk("wrap_last_avg", 32'(bus.out_avg), 0);

        // Max width
        for (int i = 0; i < 8; i++) step(1'b1, 510, 1'b1, 1'b0, "max");
        chk("max_avg", 32'(bus.out_avg), 510);
        step(1'b1, 0, 1'b1, 1'b0, "max_drop");
        chk("max_drop_avg", 32'(bus.out_avg), 446);

        // Backpressure and overrun
        step(1'b0, 0, 1'b1, 1'b1, "bp_clr");
        step(1'b1, 10, 1'b0, 1'b0, "bp_a");
        step(1'b1, 20, 1'b0, 1'b0, "bp_b");
        chk("bp_avg", 32'(bus.out_avg), 3);
        chk("bp_overrun", 32'(bus.overrun), 1);
        step(1'b0, 0, 1'b0, 1'b0, "bp_hold");
        step(1'b1, 40, 1'b1, 1'b0, "bp_simul");
        chk("bp_simul_valid", 32'(bus.out_valid), 1);
        step(1'b0, 0, 1'b1, 1'b0, "bp_drain");
        chk("bp_drain_valid", 32'(bus.out_valid), 0);

        // Clear mid-window with a colliding strobe
        step(1'b0, 0, 1'b1, 1'b1, "cl_pre");
        for (int i = 0; i < 4; i++) step(1'b1, 200, 1'b1, 1'b0, "cl_fill");
        step(1'b1, 300, 1'b1, 1'b1, "cl_clr");
        step(1'b1, 80, 1'b1, 1'b0, "cl_next");
        chk("cl_next_avg", 32'(bus.out_avg), 10);
        chk("cl_next_full", 32'(bus.out_full), 0);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 9) < 7), $urandom_range(0, 511),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) == 0), "rand");
        end

        // Asynchronous reset mid-window
        for (int i = 0; i < 5; i++) step(1'b1, $urandom_range(0, 511), 1'b1, 1'b0, "pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b1, 64, 1'b1, 1'b0, "after_rst");
        chk("after_rst_avg", 32'(bus.out_avg), 8);

        for (int i = 0; i < 100; i++) begin
            step(($urandom_range(0, 9) < 8), $urandom_range(0, 511),
                 ($urandom_range(0, 2) != 0), 1'b0, "rand2");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
`default_nettype wire
